// File: rtl/regfile_host_port_pkg.sv
// Shared constants for the 32 x 64-bit register file and the host-side blocks that drive it.
package regfile_host_port_pkg;

    localparam int RF_DATA_W    = 64;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_REG_COUNT = 1 << RF_ADDR_W;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RSP   = 3'd2,
        S_DUMP  = 3'd3,
        S_CLEAR = 3'd4,
        S_ACK   = 3'd5
    } state_t;

endpackage

// File: rtl/regfile_host_port.sv
// Host-side initiator for the register file: single READ/WRITE commands plus bulk DUMP and CLEAR.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WR    | one-cycle write strobe with latched addr/data
// RSP   | single READ beat held until rsp_ready
// DUMP  | streaming registers 0..last, one beat per handshake
// CLEAR | writing zero to register ptr, one per cycle
// ACK   | CLEAR completion beat held until rsp_ready
module regfile_host_port
    import regfile_host_port_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state, state_n;
    logic [ADDR_W-1:0]   ptr, ptr_n;
    logic [ADDR_W-1:0]   ptr_inc;
    logic [ADDR_W-1:0]   wr_addr, wr_addr_n;
    logic [DATA_W-1:0]   wr_data, wr_data_n;
    logic                rsp_valid_n, rsp_last_n;
    logic [ADDR_W-1:0]   rsp_addr_n;
    logic [DATA_W-1:0]   rsp_data_n;
    logic                cmd_fire, rsp_fire;

    assign ptr_inc   = ptr + ONE;
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            rsp_valid <= rsp_valid_n;
            rsp_last  <= rsp_last_n;
            rsp_addr  <= rsp_addr_n;
            rsp_data  <= rsp_data_n;
        end
    end

    // A DUMP captures register 0 on acceptance, so the read port must already point there.
    always_comb begin
        rf_read_reg = cmd_addr;
        case (state)
            S_IDLE:  if (cmd_op == OP_DUMP) rf_read_reg = '0;
            S_DUMP:  rf_read_reg = ptr_inc;
            default: rf_read_reg = cmd_addr;
        endcase
    end

    always_comb begin
        rf_reg_write  = 1'b0;
        rf_write_reg  = ptr;
        rf_write_data = '0;
        case (state)
            S_WR: begin
                rf_reg_write  = 1'b1;
                rf_write_reg  = wr_addr;
                rf_write_data = wr_data;
            end
            S_CLEAR: begin
                rf_reg_write  = 1'b1;
                rf_write_reg  = ptr;
                rf_write_data = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        rsp_valid_n = rsp_valid;
        rsp_last_n  = rsp_last;
        rsp_addr_n  = rsp_addr;
        rsp_data_n  = rsp_data;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_READ: begin
                            rsp_valid_n = 1'b1;
                            rsp_addr_n  = cmd_addr;
                            rsp_data_n  = rf_read_data;
                            rsp_last_n  = 1'b1;
                            state_n     = S_RSP;
                        end
                        OP_WRITE: begin
                            wr_addr_n = cmd_addr;
                            wr_data_n = cmd_wdata;
                            state_n   = S_WR;
                        end
                        OP_DUMP: begin
                            ptr_n       = '0;
                            rsp_valid_n = 1'b1;
                            rsp_addr_n  = '0;
                            rsp_data_n  = rf_read_data;
                            rsp_last_n  = 1'b0;
                            state_n     = S_DUMP;
                        end
                        default: begin
                            ptr_n   = '0;
                            state_n = S_CLEAR;
                        end
                    endcase
                end
            end
            S_WR: state_n = S_IDLE;
            S_RSP, S_ACK: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    rsp_last_n  = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            S_DUMP: begin
                if (rsp_fire) begin
                    if (ptr == LAST_IDX) begin
                        rsp_valid_n = 1'b0;
                        rsp_last_n  = 1'b0;
                        state_n     = S_IDLE;
                    end else begin
                        ptr_n      = ptr_inc;
                        rsp_addr_n = ptr_inc;
                        rsp_data_n = rf_read_data;
                        rsp_last_n = (ptr_inc == LAST_IDX);
                    end
                end
            end
            S_CLEAR: begin
                if (ptr == LAST_IDX) begin
                    rsp_valid_n = 1'b1;
                    rsp_addr_n  = LAST_IDX;
                    rsp_data_n  = '0;
                    rsp_last_n  = 1'b1;
                    state_n     = S_ACK;
                end else begin
                    ptr_n = ptr_inc;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
